raster_cmd_receiver: RTL and testbench

Raster-side endpoint of the graphics-pipe command link. It accepts SET_V0/SET_V1/SET_V2/DRAW commands from the compute-unit dispatcher over a valid/ready handshake and latches the vertices. On DRAW it computes the signed double-area, normalises winding to CCW and builds a screen-clamped bounding box. It culls degenerate and fully off-screen triangles and hands surviving triangle descriptors to the rasterizer over a second valid/ready handshake.

---
 rtl/raster_cmd_receiver.sv | 264 ++++++++++++++++++++++++++
 tb/tb_raster_cmd_receiver.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_cmd_receiver.sv
// Raster-side command endpoint: latches vertices, computes double-area and
// a clamped bounding box on DRAW, culls, and emits CCW triangle descriptors.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accepting commands (SET_Vn / NOP / DRAW)
// ST_CALC  | registering edge products and raw min/max of the vertex snapshot
// ST_FINAL | area sign/zero test, off-screen cull, descriptor registration
// ST_OUT   | descriptor valid, held until the rasterizer takes it
module raster_cmd_receiver #(
  parameter int COORD_W = 16,
  parameter int MAX_X   = 639,
  parameter int MAX_Y   = 479
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_type,
  input  logic [31:0]          cmd_data_x,
  input  logic [31:0]          cmd_data_y,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic [COORD_W-1:0]   tri_x0,
  output logic [COORD_W-1:0]   tri_y0,
  output logic [COORD_W-1:0]   tri_x1,
  output logic [COORD_W-1:0]   tri_y1,
  output logic [COORD_W-1:0]   tri_x2,
  output logic [COORD_W-1:0]   tri_y2,
  output logic [COORD_W-1:0]   tri_bbox_min_x,
  output logic [COORD_W-1:0]   tri_bbox_max_x,
  output logic [COORD_W-1:0]   tri_bbox_min_y,
  output logic [COORD_W-1:0]   tri_bbox_max_y,
  output logic [2*COORD_W+1:0] tri_area,
  output logic                 busy,
  output logic [15:0]          draw_count,
  output logic [15:0]          cull_count,
  output logic [15:0]          err_count
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2*COORD_W + 2;
  localparam int AW = 2*COORD_W + 3;

  localparam logic signed [COORD_W-1:0] LIM_X = COORD_W'(MAX_X);
  localparam logic signed [COORD_W-1:0] LIM_Y = COORD_W'(MAX_Y);

  localparam logic [2:0] CMD_SET_V0 = 3'b001;
  localparam logic [2:0] CMD_SET_V1 = 3'b010;
  localparam logic [2:0] CMD_SET_V2 = 3'b011;
  localparam logic [2:0] CMD_DRAW   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [COORD_W-1:0] vx_q [3];
  logic signed [COORD_W-1:0] vy_q [3];
  logic [2:0]                vmask_q;

  logic signed [PW-1:0]      p1_q, p2_q, p1_d, p2_d;
  logic signed [COORD_W-1:0] minx_q, maxx_q, miny_q, maxy_q;
  logic signed [COORD_W-1:0] minx_d, maxx_d, miny_d, maxy_d;

  logic signed [COORD_W-1:0] ox_q [3];
  logic signed [COORD_W-1:0] oy_q [3];
  logic signed [COORD_W-1:0] bb_minx_q, bb_maxx_q, bb_miny_q, bb_maxy_q;
  logic [PW-1:0]             area_q, area_d;

  logic [15:0] draw_q, cull_q, err_q;

  logic        accept;
  logic [2:0]  set_en;
  logic        draw_cmd, draw_go, draw_err;
  logic        unused_data;

  logic signed [DW-1:0] dx1_c, dy1_c, dx2_c, dy2_c;
  logic signed [AW-1:0] area_c;
  logic [PW-1:0]        diff_pos_c, diff_neg_c;
  logic                 neg_c, cull_c, emit_c;

  function automatic logic signed [COORD_W-1:0] min3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] clamp(
    input logic signed [COORD_W-1:0] v,
    input logic signed [COORD_W-1:0] hi
  );
    if (v[COORD_W-1]) return '0;
    else if (v > hi)  return hi;
    else              return v;
  endfunction

  // Only the low COORD_W bits of the command payload carry a coordinate.
  assign unused_data = ^{cmd_data_x[31:COORD_W], cmd_data_y[31:COORD_W]};

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign set_en[0] = accept && (cmd_type == CMD_SET_V0);
  assign set_en[1] = accept && (cmd_type == CMD_SET_V1);
  assign set_en[2] = accept && (cmd_type == CMD_SET_V2);
  assign draw_cmd  = accept && (cmd_type == CMD_DRAW);
  assign draw_go   = draw_cmd && (vmask_q == 3'b111);
  assign draw_err  = draw_cmd && (vmask_q != 3'b111);

  // Vertex store persists across draws so strips can update one vertex.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      vmask_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (set_en[i]) begin
          vx_q[i]    <= cmd_data_x[COORD_W-1:0];
          vy_q[i]    <= cmd_data_y[COORD_W-1:0];
          vmask_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    dx1_c  = DW'(vx_q[1]) - DW'(vx_q[0]);
    dy1_c  = DW'(vy_q[1]) - DW'(vy_q[0]);
    dx2_c  = DW'(vx_q[2]) - DW'(vx_q[0]);
    dy2_c  = DW'(vy_q[2]) - DW'(vy_q[0]);
    p1_d   = PW'(dx1_c) * PW'(dy2_c);
    p2_d   = PW'(dx2_c) * PW'(dy1_c);
    minx_d = min3(vx_q[0], vx_q[1], vx_q[2]);
    maxx_d = max3(vx_q[0], vx_q[1], vx_q[2]);
    miny_d = min3(vy_q[0], vy_q[1], vy_q[2]);
    maxy_d = max3(vy_q[0], vy_q[1], vy_q[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q   <= '0;
      p2_q   <= '0;
      minx_q <= '0;
      maxx_q <= '0;
      miny_q <= '0;
      maxy_q <= '0;
    end else if (state_q == ST_CALC) begin
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      minx_q <= minx_d;
      maxx_q <= maxx_d;
      miny_q <= miny_d;
      maxy_q <= maxy_d;
    end
  end

  // |A| < 2^PW, so the PW-bit wrapped difference is the exact magnitude.
  always_comb begin
    area_c     = AW'(p1_q) - AW'(p2_q);
    diff_pos_c = p1_q - p2_q;
    diff_neg_c = p2_q - p1_q;
    neg_c      = area_c[AW-1];
    area_d     = neg_c ? diff_neg_c : diff_pos_c;
    cull_c     = (area_c == '0) || maxx_q[COORD_W-1] || (minx_q > LIM_X) ||
                 maxy_q[COORD_W-1] || (miny_q > LIM_Y);
    emit_c     = (state_q == ST_FINAL) && !cull_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        ox_q[i] <= '0;
        oy_q[i] <= '0;
      end
      bb_minx_q <= '0;
      bb_maxx_q <= '0;
      bb_miny_q <= '0;
      bb_maxy_q <= '0;
      area_q    <= '0;
    end else if (emit_c) begin
      ox_q[0]   <= vx_q[0];
      oy_q[0]   <= vy_q[0];
      ox_q[1]   <= neg_c ? vx_q[2] : vx_q[1];
      oy_q[1]   <= neg_c ? vy_q[2] : vy_q[1];
      ox_q[2]   <= neg_c ? vx_q[1] : vx_q[2];
      oy_q[2]   <= neg_c ? vy_q[1] : vy_q[2];
      bb_minx_q <= clamp(minx_q, LIM_X);
      bb_maxx_q <= clamp(maxx_q, LIM_X);
      bb_miny_q <= clamp(miny_q, LIM_Y);
      bb_maxy_q <= clamp(maxy_q, LIM_Y);
      area_q    <= area_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_q <= '0;
      cull_q <= '0;
      err_q  <= '0;
    end else begin
      if (draw_err)                                err_q  <= err_q + 16'd1;
      if ((state_q == ST_FINAL) && cull_c)         cull_q <= cull_q + 16'd1;
      if ((state_q == ST_OUT) && tri_ready)        draw_q <= draw_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (draw_go) state_d = ST_CALC;
      ST_CALC:  state_d = ST_FINAL;
      ST_FINAL: state_d = cull_c ? ST_IDLE : ST_OUT;
      ST_OUT:   if (tri_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    tri_valid = (state_q == ST_OUT);
  end

  assign tri_x0         = ox_q[0];
  assign tri_y0         = oy_q[0];
  assign tri_x1         = ox_q[1];
  assign tri_y1         = oy_q[1];
  assign tri_x2         = ox_q[2];
  assign tri_y2         = oy_q[2];
  assign tri_bbox_min_x = bb_minx_q;
  assign tri_bbox_max_x = bb_maxx_q;
  assign tri_bbox_min_y = bb_miny_q;
  assign tri_bbox_max_y = bb_maxy_q;
  assign tri_area       = area_q;
  assign draw_count     = draw_q;
  assign cull_count     = cull_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_raster_cmd_receiver.sv
// Bench for raster_cmd_receiver: directed spec scenarios plus randomized
// vertex/command streams compared against an arithmetic triangle model.
module tb_raster_cmd_receiver;

  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_type;
  logic [31:0] cmd_data_x, cmd_data_y;
  logic        tri_valid;
  logic        tri_ready;
  logic [15:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
  logic [15:0] tri_bbox_min_x, tri_bbox_max_x, tri_bbox_min_y, tri_bbox_max_y;
  logic [33:0] tri_area;
  logic        busy;
  logic [15:0] draw_count, cull_count, err_count;

  raster_cmd_receiver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_data_x(cmd_data_x), .cmd_data_y(cmd_data_y),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1),
    .tri_x2(tri_x2), .tri_y2(tri_y2),
    .tri_bbox_min_x(tri_bbox_min_x), .tri_bbox_max_x(tri_bbox_max_x),
    .tri_bbox_min_y(tri_bbox_min_y), .tri_bbox_max_y(tri_bbox_max_y),
    .tri_area(tri_area), .busy(busy),
    .draw_count(draw_count), .cull_count(cull_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int      mvx [3];
  int      mvy [3];
  bit [2:0] mmask;
  int      m_draw, m_cull, m_err;
  int      ex [3];
  int      ey [3];
  int      ebb [4];
  longint  earea;
  int      ekind;  // 0 = rejected DRAW, 1 = culled, 2 = emitted

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic int iclamp(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mvx[i] = 0;
      mvy[i] = 0;
    end
    mmask  = 3'b000;
    m_draw = 0;
    m_cull = 0;
    m_err  = 0;
  endfunction

  // Signed double area via the cross product; negative means clockwise.
  function automatic void model_draw();
    longint a;
    int mnx, mxx, mny, mxy;
    if (mmask != 3'b111) begin
      ekind = 0;
      return;
    end
    a = longint'(mvx[1] - mvx[0]) * longint'(mvy[2] - mvy[0]) -
        longint'(mvx[2] - mvx[0]) * longint'(mvy[1] - mvy[0]);
    mnx = imin3(mvx[0], mvx[1], mvx[2]);
    mxx = imax3(mvx[0], mvx[1], mvx[2]);
    mny = imin3(mvy[0], mvy[1], mvy[2]);
    mxy = imax3(mvy[0], mvy[1], mvy[2]);
    if (a == 0 || mxx < 0 || mnx > MAX_X || mxy < 0 || mny > MAX_Y) begin
      ekind = 1;
      return;
    end
    ekind = 2;
    ex[0] = mvx[0];
    ey[0] = mvy[0];
    ex[1] = (a < 0) ? mvx[2] : mvx[1];
    ey[1] = (a < 0) ? mvy[2] : mvy[1];
    ex[2] = (a < 0) ? mvx[1] : mvx[2];
    ey[2] = (a < 0) ? mvy[1] : mvy[2];
    earea = (a < 0) ? -a : a;
    ebb[0] = iclamp(mnx, MAX_X);
    ebb[1] = iclamp(mxx, MAX_X);
    ebb[2] = iclamp(mny, MAX_Y);
    ebb[3] = iclamp(mxy, MAX_Y);
  endfunction

  task automatic send_cmd(input logic [2:0] t, input int x, input int y);
    int n;
    logic acc;
    logic [31:0] g;
    n   = 0;
    acc = 1'b0;
    g   = $urandom();
    cmd_type   = t;
    cmd_data_x = {g[31:16], x[15:0]};
    g   = $urandom();
    cmd_data_y = {g[31:16], y[15:0]};
    cmd_valid  = 1'b1;
    while (!acc && n < 20) begin
      acc = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", acc, 1);
    if (acc && t >= 3'd1 && t <= 3'd3) begin
      mvx[t-1]   = int'(shortint'(x[15:0]));
      mvy[t-1]   = int'(shortint'(y[15:0]));
      mmask[t-1] = 1'b1;
    end
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
    send_cmd(3'd1, x0, y0);
    send_cmd(3'd2, x1, y1);
    send_cmd(3'd3, x2, y2);
  endtask

  task automatic check_desc();
    check("tri_x0", $signed(tri_x0), ex[0]);
    check("tri_y0", $signed(tri_y0), ey[0]);
    check("tri_x1", $signed(tri_x1), ex[1]);
    check("tri_y1", $signed(tri_y1), ey[1]);
    check("tri_x2", $signed(tri_x2), ex[2]);
    check("tri_y2", $signed(tri_y2), ey[2]);
    check("bbox_min_x", $signed(tri_bbox_min_x), ebb[0]);
    check("bbox_max_x", $signed(tri_bbox_max_x), ebb[1]);
    check("bbox_min_y", $signed(tri_bbox_min_y), ebb[2]);
    check("bbox_max_y", $signed(tri_bbox_max_y), ebb[3]);
    check("tri_area", tri_area, earea);
  endtask

  // Issue DRAW and follow it to completion; hold = cycles of backpressure
  // in OUT, during which a SET_V0 is presented and must not be consumed.
  task automatic do_draw(input int hold, input longint want_area);
    int lat;
    model_draw();
    send_cmd(3'd4, 0, 0);
    if (ekind == 0) begin
      m_err++;
      check("err_busy", busy, 0);
      check("err_tri_valid", tri_valid, 0);
      step();
      check("err_busy_next", busy, 0);
      check("err_count", err_count, m_err & 16'hFFFF);
    end else if (ekind == 1) begin
      m_cull++;
      check("cull_busy_calc", busy, 1);
      check("cull_ready_calc", cmd_ready, 0);
      step();
      check("cull_busy_final", busy, 1);
      check("cull_tri_valid", tri_valid, 0);
      step();
      check("cull_ready_back", cmd_ready, 1);
      check("cull_tri_valid_idle", tri_valid, 0);
      check("cull_count", cull_count, m_cull & 16'hFFFF);
    end else begin
      tri_ready = (hold == 0);
      lat = 1;
      while (!tri_valid && lat < 12) begin
        step();
        lat++;
      end
      check("tri_valid_seen", tri_valid, 1);
      check("latency", lat, 3);
      check("out_cmd_ready", cmd_ready, 0);
      check_desc();
      if (want_area >= 0) check("directed_area", tri_area, want_area);
      for (int i = 0; i < hold; i++) begin
        cmd_valid  = 1'b1;
        cmd_type   = 3'd1;
        cmd_data_x = 32'd123;
        cmd_data_y = 32'd321;
        step();
        check("hold_tri_valid", tri_valid, 1);
        check("hold_cmd_ready", cmd_ready, 0);
        check_desc();
      end
      cmd_valid = 1'b0;
      tri_ready = 1'b1;
      step();
      m_draw++;
      check("post_tri_valid", tri_valid, 0);
      check("post_cmd_ready", cmd_ready, 1);
      check("draw_count", draw_count, m_draw & 16'hFFFF);
      tri_ready = 1'b0;
    end
  endtask

  function automatic int rand_coord(input bit is_y);
    if ($urandom_range(0, 3) == 0) return int'(shortint'($urandom_range(0, 65535)));
    if (is_y) return int'($urandom_range(0, 600)) - 60;
    return int'($urandom_range(0, 800)) - 80;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, t;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_type   = 3'd0;
    cmd_data_x = '0;
    cmd_data_y = '0;
    tri_ready  = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tri_valid", tri_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tri_area", tri_area, 0);
    check("rst_tri_x1", tri_x1, 0);
    check("rst_draw_count", draw_count, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    step();

    // Incomplete vertex set: DRAW rejected
    send_cmd(3'd1, 0, 0);
    send_cmd(3'd2, 10, 0);
    do_draw(0, -1);

    // Basic CCW triangle, then swapped winding
    send_cmd(3'd3, 0, 10);
    do_draw(0, 100);
    send_cmd(3'd2, 0, 10);
    send_cmd(3'd3, 10, 0);
    do_draw(0, 100);

    // Degenerate, partially off-screen, fully off-screen
    set_tri(0, 0, 5, 5, 10, 10);
    do_draw(0, -1);
    set_tri(-20, -20, 50, -5, -5, 700);
    do_draw(0, 50175);
    set_tri(700, 10, 800, 20, 900, 5);
    do_draw(0, -1);

    // Backpressure, then confirm the presented SET_V0 was not taken
    set_tri(0, 0, 10, 0, 0, 10);
    do_draw(5, 100);
    do_draw(0, 100);

    // Randomized command streams
    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        k = $urandom_range(0, 9);
        if (k == 0) begin
          t = $urandom_range(4, 7);
          send_cmd((t == 4) ? 3'd0 : 3'(t), rand_coord(0), rand_coord(1));
        end else if (k == 1) begin
          send_cmd(3'd3, mvx[0], mvy[0]);
        end else begin
          t = $urandom_range(1, 3);
          send_cmd(3'(t), rand_coord(0), rand_coord(1));
        end
      end
      do_draw($urandom_range(0, 3), -1);
    end
    check("final_draw_count", draw_count, m_draw & 16'hFFFF);
    check("final_cull_count", cull_count, m_cull & 16'hFFFF);
    check("final_err_count", err_count, m_err & 16'hFFFF);

    // Reset while in CALC
    set_tri(0, 0, 10, 0, 0, 10);
    send_cmd(3'd4, 0, 0);
    check("calc_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_tri_valid", tri_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_draw_count", draw_count, 0);
    check("midrst_tri_area", tri_area, 0);
    step();
    rst = 1'b0;
    model_reset();
    step();
    do_draw(0, -1);
    check("midrst_err_one", err_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
